// File: rtl/cpu_mul_seq_pkg.sv
// cpu_mul_pkg: shared op encodings, sequencer state enum and default
// partial-product cell latency for the cpu_mul_seq multiply sequencer.
package cpu_mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSS = 2'b10;
    localparam logic [1:0] OP_MULXSU = 2'b11;

    localparam int PP_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Shift code carried with each partial product:
    // k=0 -> 0 (x1), k=1,2 -> 1 (x2^16), k=3 -> 2 (x2^32).
    function automatic logic [1:0] pp_shift(input logic [1:0] k);
        return {k[1] & k[0], k[1] ^ k[0]};
    endfunction

endpackage

// File: rtl/cpu_mul_seq_if.sv
// cpu_mul_seq_if: request/response handshake bundle between the M-stage
// issue logic (master) and the multiply sequencer (slave).
interface cpu_mul_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );

endinterface

// File: rtl/cpu_mul_seq_pp16.sv
// cpu_mul_pp16: registered 16x16 unsigned multiplier, PP_LAT register
// stages deep; intended to map onto a single DSP multiplier.
module cpu_mul_pp16 #(
    parameter int PP_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);

    logic [PP_LAT-1:0][31:0] r_pipe;

    // Product enters stage 0, then shifts through the remaining stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= {16'b0, i_a} * {16'b0, i_b};
            for (int i = 1; i < PP_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_p = r_pipe[PP_LAT-1];

endmodule

// File: rtl/cpu_mul_seq.sv
// cpu_mul_seq: multi-cycle 32x32 multiply built from 16x16 partial
// products. Define CPU_MUL_SEQ_SIGNED_EN to enable signed high-word
// correction for MULXSS/MULXSU; without it they return the unsigned high word.
module cpu_mul_seq
    import cpu_mul_pkg::*;
#(
    parameter int PP_LAT = PP_LAT_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    cpu_mul_seq_if.slave bus
);

    state_t                r_state;
    logic [1:0]            r_op;
    logic [31:0]           r_a;
    logic [31:0]           r_b;
    logic [63:0]           r_acc;
    logic [1:0]            r_k;
    logic [1:0]            r_dcnt;
    logic [31:0]           r_rsp_result;
    logic [PP_LAT:1]       r_vld_pipe;
    logic [PP_LAT:1][1:0]  r_sh_pipe;

    logic                  w_issue;
    logic [1:0]            w_last_k;
    logic [15:0]           w_pp_a;
    logic [15:0]           w_pp_b;
    logic [31:0]           w_pp_p;
    logic [63:0]           w_pp_sh;
    logic [31:0]           w_hi;

    // MUL needs only the three products that reach the low word.
    assign w_last_k = (r_op == OP_MUL) ? 2'd2 : 2'd3;
    assign w_issue  = (r_state == ISSUE);

    // k[0] picks the A half, k[1] the B half: aL*bL, aH*bL, aL*bH, aH*bH.
    assign w_pp_a = r_k[0] ? r_a[31:16] : r_a[15:0];
    assign w_pp_b = r_k[1] ? r_b[31:16] : r_b[15:0];

    cpu_mul_pp16 #(.PP_LAT(PP_LAT)) u_pp (
        .clk     (clk),
        .reset_n (reset_n),
        .i_a     (w_pp_a),
        .i_b     (w_pp_b),
        .o_p     (w_pp_p)
    );

    // Product aligned by the shift code travelling with it (0/16/32).
    assign w_pp_sh = {32'b0, w_pp_p} << {r_sh_pipe[PP_LAT], 4'b0000};

    // Sign correction on the unsigned high word, mod 2^32.
    always_comb begin
        w_hi = r_acc[63:32];
`ifdef CPU_MUL_SEQ_SIGNED_EN
        if ((r_op == OP_MULXSS || r_op == OP_MULXSU) && r_a[31])
            w_hi = w_hi - r_b;
        if ((r_op == OP_MULXSS) && r_b[31])
            w_hi = w_hi - r_a;
`endif
    end

    // Tag pipeline: valid and shift code track each product through the cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_sh_pipe  <= '0;
        end else begin
            r_vld_pipe[1] <= w_issue;
            r_sh_pipe[1]  <= pp_shift(r_k);
            for (int i = 2; i <= PP_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_sh_pipe[i]  <= r_sh_pipe[i-1];
            end
        end
    end

    // Sequencer FSM, operand capture, accumulation and result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_k          <= '0;
            r_dcnt       <= '0;
            r_rsp_result <= '0;
        end else begin
            if (r_vld_pipe[PP_LAT])
                r_acc <= r_acc + w_pp_sh;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_a     <= bus.req_src1;
                        r_b     <= bus.req_src2;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == w_last_k) begin
                        r_dcnt  <= '0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_dcnt <= r_dcnt + 2'd1;
                    if (r_dcnt == 2'(PP_LAT - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_rsp_result <= (r_op == OP_MUL) ? r_acc[31:0] : w_hi;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.busy       = (r_state != IDLE);
    assign bus.rsp_result = r_rsp_result;

endmodule

// File: tb/tb_cpu_mul_seq.sv
// tb_cpu_mul_seq: directed bench for cpu_mul_seq; expected values follow
// CPU_MUL_SEQ_SIGNED_EN when the bench is built with the macro defined.
module tb_cpu_mul_seq;
    import cpu_mul_pkg::*;

    localparam int PPL     = 1;
    localparam int LAT_MUL = 3 + PPL + 1;
    localparam int LAT_HI  = 4 + PPL + 1;

`ifdef CPU_MUL_SEQ_SIGNED_EN
    localparam logic [31:0] EXP_SS_M1X2 = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_SS_MIN  = 32'h4000_0000;
    localparam logic [31:0] EXP_SU_M1   = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_SS_M1X2 = 32'h0000_0001;
    localparam logic [31:0] EXP_SS_MIN  = 32'h4000_0000;
    localparam logic [31:0] EXP_SU_M1   = 32'hFFFF_FFFE;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    cpu_mul_seq_if bus();

    cpu_mul_seq #(.PP_LAT(PPL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after accept, wait (bounded) for
    // the response, check latency/result, then complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = ~op;
        bus.req_src1  = 32'hDEAD_BEEF;
        bus.req_src2  = 32'h1234_5678;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".result"}, bus.rsp_result, exp);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ".rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".req_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int wait_cnt;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_MUL;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst.req_ready",  32'(bus.req_ready), 32'd1);
        chk("rst.rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_result", bus.rsp_result,     32'd0);
        chk("rst.busy",       32'(bus.busy),      32'd0);
        reset_n = 1'b1;

        // Basic low/high word and all-ones operands
        run_op("mul_small",   OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, LAT_MUL);
        run_op("mulxuu_small",OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, LAT_HI);
        run_op("mulxuu_ones", OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_HI);
        run_op("mul_ones",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_MUL);

        // Signed high-word ops
        run_op("mulxss_m1x2", OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, EXP_SS_M1X2, LAT_HI);
        run_op("mulxss_min",  OP_MULXSS, 32'h8000_0000, 32'h8000_0000, EXP_SS_MIN,  LAT_HI);
        run_op("mulxsu_ones", OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_SU_M1,   LAT_HI);

        // Backpressure: response held while a new request waits
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        bus.req_src1  = 32'h0000_1234;
        bus.req_src2  = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        bus.req_op    = OP_MULXUU;
        bus.req_src1  = 32'h7777_7777;
        bus.req_src2  = 32'h3333_3333;
        wait_cnt = 0;
        while (!bus.rsp_valid && wait_cnt < 40) begin
            @(posedge clk);
            wait_cnt++;
            @(negedge clk);
        end
        chk("bp.latency", 32'(wait_cnt), 32'(LAT_MUL));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp.result_hold", bus.rsp_result,     32'h0001_2340);
            chk("bp.req_ready",   32'(bus.req_ready), 32'd0);
            chk("bp.rsp_valid",   32'(bus.rsp_valid), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("bp.release_rdy",   32'(bus.req_ready), 32'd1);
        chk("bp.release_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.no_second_accept", 32'(bus.busy), 32'd0);

        // Reset during ISSUE
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        bus.req_src1  = 32'h0000_FFFF;
        bus.req_src2  = 32'h0000_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rmid.busy_before", 32'(bus.busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rmid.rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rmid.busy",       32'(bus.busy),      32'd0);
        chk("rmid.req_ready",  32'(bus.req_ready), 32'd1);
        chk("rmid.rsp_result", bus.rsp_result,     32'd0);
        #1 reset_n = 1'b1;
        run_op("mul_after_rst", OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, LAT_MUL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
